sys_debug_ctrl: RTL

Run-control and observation block that sits between the board clock and the MIPS core. It generates a parametrised CPU clock-enable, replacing a fixed divisor, with halt, single-step and run-to-breakpoint modes. It drives a debug LED word selected from NUM_CH probe channels, plus a heartbeat LED. Successor to the fixed-divisor, fixed-selector system front end; the core advances only on cycles where cpu_en is high.

---
 rtl/sys_dbg_pkg.sv | 28 ++
 rtl/sys_debounce.sv | 49 ++++
 rtl/sys_debug_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sys_dbg_pkg.sv
// Run-control encodings shared by the debug controller and its bench.
// Pure definitions, no latency or flow control involved.
package sys_dbg_pkg;

   localparam logic [1:0] MODE_HALT = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;
   localparam logic [1:0] MODE_BRK  = 2'b11;

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_BRK  = 2'b11
   } state_t;

   function automatic state_t mode_to_state(input logic [1:0] mode);
      state_t st;
      case (mode)
         MODE_RUN:  st = S_RUN;
         MODE_STEP: st = S_STEP;
         MODE_BRK:  st = S_BRK;
         default:   st = S_HALT;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/sys_debounce.sv
// Step button: 2-flop sync, DEB_CYCLES-sample debounce, registered rising-edge pulse.
// Pulse appears DEB_CYCLES+3 edges after a clean press; no backpressure, pulse is fire-and-forget.
module sys_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic [CW-1:0] r_cnt;
   logic          r_stable;
   logic          r_stable_q;
   logic          r_pulse;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_cnt      <= '0;
         r_stable   <= 1'b0;
         r_stable_q <= 1'b0;
         r_pulse    <= 1'b0;
      end else begin
         r_sync1    <= i_btn;
         r_sync2    <= r_sync1;
         r_stable_q <= r_stable;
         r_pulse    <= r_stable & ~r_stable_q;
         // counter tracks a run of samples disagreeing with the stable level
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/sys_debug_ctrl.sv
// CPU clock-enable generator (halt/run/step/run-to-break) plus debug LED mux and heartbeat.
// All outputs registered, one cycle behind their inputs; the core has no way to stall this block.
module sys_debug_ctrl
   import sys_dbg_pkg::*;
#(
   parameter  int DIVISOR    = 25_000_000,
   parameter  int NUM_CH     = 8,
   parameter  int CH_W       = 27,
   parameter  int PC_W       = 32,
   parameter  int DEB_CYCLES = 16,
   localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                   clk,
   input  logic                   SYS_reset,
   input  logic [1:0]             SYS_mode,
   input  logic                   SYS_step,
   input  logic [PC_W-1:0]        SYS_bp_addr,
   input  logic [SEL_W-1:0]       SYS_output_sel,
   input  logic [PC_W-1:0]        dbg_pc,
   input  logic [NUM_CH*CH_W-1:0] dbg_data,
   output logic                   cpu_en,
   output logic [CH_W-1:0]        SYS_leds,
   output logic                   CLK_led,
   output logic                   bp_hit
);

   localparam int CNT_W = $clog2(DIVISOR) + 1;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIVISOR - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cpu_en;
   logic             r_clk_led;
   logic             r_bp_hit;
   logic [CH_W-1:0]  r_leds;

   logic             w_tick;
   logic             w_pc_match;
   logic             w_step_req;
   logic             w_counting;
   logic             w_en_nxt;
   logic             w_bp_set;
   logic [CH_W-1:0]  w_led_nxt;

   sys_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_step_deb (
      .i_clk   (clk),
      .i_rst   (SYS_reset),
      .i_btn   (SYS_step),
      .o_pulse (w_step_req)
   );

   always_ff @(posedge clk) begin
      if (SYS_reset) begin
         r_state <= S_HALT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = mode_to_state(SYS_mode);
   end

   assign w_tick     = (r_cnt == DIV_LAST);
   assign w_pc_match = (dbg_pc == SYS_bp_addr);
   assign w_counting = (r_state == S_RUN) || (r_state == S_BRK);

   // enable is decided by the state in force before the edge, so a tick
   // already due on a mode-change edge is still delivered
   always_comb begin
      w_en_nxt = 1'b0;
      w_bp_set = 1'b0;
      case (r_state)
         S_RUN:  w_en_nxt = w_tick;
         S_BRK: begin
            w_en_nxt = w_tick & ~r_bp_hit & ~w_pc_match;
            w_bp_set = w_tick & w_pc_match;
         end
         S_STEP: w_en_nxt = w_step_req;
         default: w_en_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (SYS_reset) begin
         r_cnt <= '0;
      end else if ((w_state_nxt != r_state) || !w_counting || w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (SYS_reset) begin
         r_cpu_en  <= 1'b0;
         r_clk_led <= 1'b0;
         r_bp_hit  <= 1'b0;
      end else begin
         r_cpu_en  <= w_en_nxt;
         r_clk_led <= r_clk_led ^ w_en_nxt;
         if (r_state != S_BRK) begin
            r_bp_hit <= 1'b0;
         end else if (w_bp_set) begin
            r_bp_hit <= 1'b1;
         end
      end
   end

   // out-of-range selects match no channel and fall through to zero
   always_comb begin
      w_led_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (SYS_output_sel == SEL_W'(i)) begin
            w_led_nxt = dbg_data[i*CH_W +: CH_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (SYS_reset) begin
         r_leds <= '0;
      end else begin
         r_leds <= w_led_nxt;
      end
   end

   assign cpu_en   = r_cpu_en;
   assign CLK_led  = r_clk_led;
   assign bp_hit   = r_bp_hit;
   assign SYS_leds = r_leds;

endmodule
